// File: rtl/fdma_wframe_sched_pkg.sv
// Shared constants for the FDMA frame write scheduler: FSM encoding,
// buffer-index width and the burst address increment.
package fdma_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_DATA = 3'd1;
  localparam logic [2:0] ST_REQ       = 3'd2;
  localparam logic [2:0] ST_BUSY      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam int BUF_IDX_W = 2;

  // Byte distance between consecutive bursts of one frame.
  function automatic int unsigned addr_inc(input int unsigned burst_len,
                                           input int unsigned data_width);
    return burst_len * (data_width / 8);
  endfunction

endpackage

// File: rtl/fdma_burst_req.sv
// One FDMA burst handshake: raise wareq until the arbiter reports busy,
// then flag the end of the burst on the falling edge of wbusy.
module fdma_burst_req #(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       size,
  input  logic              wbusy,
  output logic              wareq,
  output logic [ADDR_W-1:0] waddr,
  output logic [15:0]       wsize,
  output logic              burst_end
);

  logic              req_q;
  logic              busy_q;
  logic              wbusy_dly_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wsize_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      wbusy_dly_q <= 1'b0;
      waddr_q     <= '0;
      wsize_q     <= '0;
    end else begin
      wbusy_dly_q <= wbusy;
      if (start) begin
        req_q   <= 1'b1;
        busy_q  <= 1'b0;
        waddr_q <= addr;
        wsize_q <= size;
      end else if (req_q && wbusy) begin
        req_q  <= 1'b0;
        busy_q <= 1'b1;
      end else if (burst_end) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign burst_end = busy_q & wbusy_dly_q & ~wbusy;
  assign wareq     = req_q;
  assign waddr     = waddr_q;
  assign wsize     = wsize_q;

endmodule

// File: rtl/fdma_wframe_sched.sv
// Per-channel frame write scheduler: drains the video FIFO in bursts,
// rotates frame buffers and publishes the last completed one.
module fdma_wframe_sched
  import fdma_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 21,
  parameter int unsigned BURST_LEN      = 256,
  parameter int unsigned FRAME_BURSTS   = 300,
  parameter int unsigned BUF_NUM        = 3,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned BUF_STRIDE     = 'h80000
) (
  input  logic                      ui_clk,
  input  logic                      ui_rst,
  input  logic                      frame_start,
  input  logic [15:0]               fifo_rd_cnt,
  output logic                      fifo_rden,
  output logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
  output logic                      fdma_wareq,
  output logic [15:0]               fdma_wsize,
  input  logic                      fdma_wbusy,
  input  logic                      fdma_wvalid,
  output logic [BUF_IDX_W-1:0]      wbuf_idx,
  output logic [BUF_IDX_W-1:0]      rbuf_idx,
  output logic                      rbuf_valid,
  output logic                      frame_done,
  output logic                      frame_drop
);

  localparam int                   CNT_W    = $clog2(FRAME_BURSTS + 1);
  localparam logic [31:0]          ADDR_INC = addr_inc(BURST_LEN, AXI_DATA_WIDTH);
  localparam logic [15:0]          WSIZE    = 16'(BURST_LEN);
  localparam logic [BUF_IDX_W-1:0] LAST_BUF = BUF_IDX_W'(BUF_NUM - 1);
  localparam logic [CNT_W-1:0]     LAST_BST = CNT_W'(FRAME_BURSTS - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [BUF_IDX_W-1:0] wbuf_q, wbuf_d;
  logic [BUF_IDX_W-1:0] rbuf_q, rbuf_d;
  logic                 rvalid_q, rvalid_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 drop_q, drop_d;
  logic                 start_req;
  logic                 burst_end;
  logic [AXI_ADDR_WIDTH-1:0] addr_calc;

  assign addr_calc = AXI_ADDR_WIDTH'(BASE_ADDR + 32'(wbuf_q) * BUF_STRIDE
                                     + 32'(burst_cnt_q) * ADDR_INC);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wbuf_d      = wbuf_q;
    rbuf_d      = rbuf_q;
    rvalid_d    = rvalid_q;
    pend_d      = pend_q;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    start_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d     = ST_WAIT_DATA;
          burst_cnt_d = '0;
        end
      end
      ST_WAIT_DATA: begin
        // A new frame start here abandons the partial frame on the same buffer.
        if (frame_start) begin
          drop_d      = 1'b1;
          burst_cnt_d = '0;
        end else if (fifo_rd_cnt >= WSIZE && !fdma_wbusy) begin
          state_d   = ST_REQ;
          start_req = 1'b1;
        end
      end
      ST_REQ: begin
        if (frame_start) pend_d = 1'b1;
        if (fdma_wbusy) state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (frame_start) pend_d = 1'b1;
        if (burst_end) begin
          if (burst_cnt_q == LAST_BST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (pend_q || frame_start) begin
            state_d     = ST_WAIT_DATA;
            drop_d      = 1'b1;
            burst_cnt_d = '0;
            pend_d      = 1'b0;
          end else begin
            state_d     = ST_WAIT_DATA;
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        rbuf_d   = wbuf_q;
        rvalid_d = 1'b1;
        wbuf_d   = (wbuf_q == LAST_BUF) ? '0 : wbuf_q + BUF_IDX_W'(1);
        if (pend_q || frame_start) begin
          state_d     = ST_WAIT_DATA;
          burst_cnt_d = '0;
          pend_d      = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      wbuf_q      <= '0;
      rbuf_q      <= '0;
      rvalid_q    <= 1'b0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      rvalid_q    <= rvalid_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  fdma_burst_req #(
    .ADDR_W(AXI_ADDR_WIDTH)
  ) u_burst_req (
    .clk      (ui_clk),
    .rst      (ui_rst),
    .start    (start_req),
    .addr     (addr_calc),
    .size     (WSIZE),
    .wbusy    (fdma_wbusy),
    .wareq    (fdma_wareq),
    .waddr    (fdma_waddr),
    .wsize    (fdma_wsize),
    .burst_end(burst_end)
  );

  assign fifo_rden  = fdma_wvalid && (state_q == ST_BUSY);
  assign wbuf_idx   = wbuf_q;
  assign rbuf_idx   = rbuf_q;
  assign rbuf_valid = rvalid_q;
  assign frame_done = done_q;
  assign frame_drop = drop_q;

endmodule

// File: tb/tb_fdma_wframe_sched.sv
// Directed/randomized bench for fdma_wframe_sched with an arbiter model and
// a buffer-rotation reference model.
module tb_fdma_wframe_sched;

  localparam int BL     = 16;
  localparam int FB     = 4;
  localparam int NB     = 3;
  localparam int STRIDE = 'h1000;
  localparam int INC    = BL * 4;

  logic        ui_clk = 1'b0;
  logic        ui_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [15:0] fifo_rd_cnt = 16'd0;
  logic        fdma_wbusy = 1'b0;
  logic        fdma_wvalid = 1'b0;
  logic        fifo_rden;
  logic [20:0] fdma_waddr;
  logic        fdma_wareq;
  logic [15:0] fdma_wsize;
  logic [1:0]  wbuf_idx;
  logic [1:0]  rbuf_idx;
  logic        rbuf_valid;
  logic        frame_done;
  logic        frame_drop;

  fdma_wframe_sched #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(21), .BURST_LEN(BL), .FRAME_BURSTS(FB),
    .BUF_NUM(NB), .BASE_ADDR(0), .BUF_STRIDE(STRIDE)
  ) dut (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .frame_start(frame_start),
    .fifo_rd_cnt(fifo_rd_cnt), .fifo_rden(fifo_rden), .fdma_waddr(fdma_waddr),
    .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize), .fdma_wbusy(fdma_wbusy),
    .fdma_wvalid(fdma_wvalid), .wbuf_idx(wbuf_idx), .rbuf_idx(rbuf_idx),
    .rbuf_valid(rbuf_valid), .frame_done(frame_done), .frame_drop(frame_drop)
  );

  always #5 ui_clk = ~ui_clk;

  int errors = 0;
  int checks = 0;

  // Arbiter model state and observation counters.
  int          arb_phase = 0;
  int          arb_dly = 0;
  int          arb_beats = 0;
  int          stale_cnt = 0;
  bit          stale_mode = 1'b0;
  logic [31:0] req_q[$];
  int          rden_cnt = 0, done_cnt = 0, drop_cnt = 0, viol_cnt = 0;
  logic        wareq_prev = 1'b0;

  initial forever begin
    @(negedge ui_clk);
    if (fifo_rden)  rden_cnt++;
    if (frame_done) done_cnt++;
    if (frame_drop) drop_cnt++;
    if (fdma_wareq && !wareq_prev && fdma_wbusy) viol_cnt++;
    wareq_prev = fdma_wareq;
    if (stale_mode) begin
      arb_phase  = 4;
      stale_mode = 1'b0;
    end
    case (arb_phase)
      0: if (fdma_wareq) begin
           req_q.push_back(32'(fdma_waddr));
           arb_dly   = $urandom_range(1, 3);
           arb_phase = 1;
         end
      1: begin
           arb_dly--;
           if (arb_dly == 0) begin
             fdma_wbusy = 1'b1;
             arb_phase  = 2;
           end
         end
      2: begin
           arb_phase   = 3;
           arb_beats   = BL;
           fdma_wvalid = ($urandom_range(0, 3) != 0);
           if (fdma_wvalid) arb_beats--;
         end
      3: begin
           if (arb_beats == 0) begin
             fdma_wbusy  = 1'b0;
             fdma_wvalid = 1'b0;
             arb_phase   = 0;
           end else begin
             fdma_wvalid = ($urandom_range(0, 3) != 0);
             if (fdma_wvalid) arb_beats--;
           end
         end
      default: begin
           // Stale burst: busy stays high through reset and 5 cycles after it.
           fdma_wbusy  = 1'b1;
           fdma_wvalid = 1'b0;
           if (ui_rst) stale_cnt = 5;
           else if (stale_cnt > 0) stale_cnt--;
           else begin
             fdma_wbusy = 1'b0;
             arb_phase  = 0;
           end
         end
    endcase
  end

  // Reference model: buffer rotation and address arithmetic.
  int m_wbuf = 0, m_rbuf = 0, m_rvalid = 0;
  int done_base = 0;

  function automatic logic [31:0] exp_addr(input int b, input int k);
    return 32'(b * STRIDE + k * INC);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(negedge ui_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    done_base   = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic get_req(output logic [31:0] a);
    int n = 0;
    while (req_q.size() == 0 && n < 4000) begin tick(); n++; end
    if (req_q.size() == 0) a = 32'hFFFF_FFFF;
    else a = req_q.pop_front();
  endtask

  task automatic get_bursts(input string tag, input int from, input int to);
    logic [31:0] a;
    for (int k = from; k <= to; k++) begin
      get_req(a);
      chk($sformatf("%s_addr_b%0d", tag, k), a, exp_addr(m_wbuf, k));
    end
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while (done_cnt <= done_base && n < 4000) begin tick(); n++; end
    tick(2);
    chk({tag, "_done_once"}, done_cnt, done_base + 1);
    m_rbuf   = m_wbuf;
    m_rvalid = 1;
    m_wbuf   = (m_wbuf + 1) % NB;
    chk({tag, "_rbuf"}, rbuf_idx, m_rbuf);
    chk({tag, "_wbuf"}, wbuf_idx, m_wbuf);
    chk({tag, "_rvalid"}, rbuf_valid, m_rvalid);
    done_base = done_cnt;
  endtask

  task automatic wait_mid_burst(input string tag);
    int n = 0;
    while (!(arb_phase == 3 && arb_beats >= 8) && n < 2000) begin tick(); n++; end
    chk({tag, "_mid_burst_reached"}, n < 2000, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wareq"}, fdma_wareq, 0);
    chk({tag, "_waddr"}, fdma_waddr, 0);
    chk({tag, "_wsize"}, fdma_wsize, 0);
    chk({tag, "_rden"}, fifo_rden, 0);
    chk({tag, "_wbuf"}, wbuf_idx, 0);
    chk({tag, "_rbuf"}, rbuf_idx, 0);
    chk({tag, "_rvalid"}, rbuf_valid, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_drop"}, frame_drop, 0);
  endtask

  initial begin
    logic [31:0] a;
    int r0, d0, dn0, seen, n;

    tick(3);
    chk_reset_outputs("por");
    ui_rst = 1'b0;
    tick(2);

    // Basic frame on buffer 0.
    fifo_rd_cnt = 16'd64;
    r0 = rden_cnt; d0 = drop_cnt;
    pulse_start();
    get_bursts("basic", 0, FB - 1);
    chk("basic_wsize", fdma_wsize, BL);
    finish_frame("basic");
    chk("basic_rden", rden_cnt - r0, FB * BL);
    chk("basic_nodrop", drop_cnt - d0, 0);
    $display("basic frame: rbuf=%0d wbuf=%0d", rbuf_idx, wbuf_idx);

    // Data starvation, then just enough data.
    fifo_rd_cnt = 16'd15;
    pulse_start();
    seen = 0;
    repeat (50) begin tick(); if (fdma_wareq) seen++; end
    chk("starve_no_wareq", seen, 0);
    fifo_rd_cnt = 16'd16;
    n = 0;
    while (!fdma_wareq && n < 10) begin tick(); n++; end
    chk("starve_wareq_within_2", n <= 2, 1);
    get_bursts("starve", 0, FB - 1);
    finish_frame("starve");
    $display("starvation frame: latency=%0d rbuf=%0d", n, rbuf_idx);

    // Third frame completes the rotation and wraps the write buffer.
    fifo_rd_cnt = 16'($urandom_range(16, 2000));
    pulse_start();
    get_bursts("rot", 0, FB - 1);
    finish_frame("rot");
    chk("rot_wrap_wbuf0", wbuf_idx, 0);
    $display("rotation frame: rbuf=%0d wbuf=%0d", rbuf_idx, wbuf_idx);

    // Restart during burst 1: frame dropped, restart at offset 0 of same buffer.
    fifo_rd_cnt = 16'($urandom_range(16, 2000));
    r0 = rden_cnt; d0 = drop_cnt; dn0 = done_cnt;
    pulse_start();
    get_bursts("rs_first", 0, 1);
    wait_mid_burst("rs");
    pulse_start();
    get_req(a);
    chk("rs_restart_addr", a, exp_addr(m_wbuf, 0));
    chk("rs_drop", drop_cnt - d0, 1);
    chk("rs_no_done", done_cnt - dn0, 0);
    get_bursts("rs_second", 1, FB - 1);
    finish_frame("rs");
    chk("rs_rden", rden_cnt - r0, (2 + FB) * BL);
    $display("restart during burst: drops=%0d rbuf=%0d", drop_cnt - d0, rbuf_idx);

    // Restart during the last burst: completion publishes, restart on next buffer.
    fifo_rd_cnt = 16'($urandom_range(16, 2000));
    d0 = drop_cnt;
    pulse_start();
    get_bursts("sim_a", 0, FB - 1);
    wait_mid_burst("sim");
    pulse_start();
    finish_frame("sim_a");
    get_bursts("sim_b", 0, FB - 1);
    chk("sim_no_drop", drop_cnt - d0, 0);
    finish_frame("sim_b");
    $display("restart on last burst: rbuf=%0d wbuf=%0d", rbuf_idx, wbuf_idx);

    // Reset mid-burst with a stale busy from the arbiter, twice.
    pulse_start();
    for (int pass = 0; pass < 2; pass++) begin
      get_req(a);
      chk($sformatf("rst%0d_first_addr", pass), a, exp_addr(m_wbuf, 0));
      wait_mid_burst($sformatf("rst%0d", pass));
      ui_rst = 1'b1;
      stale_mode = 1'b1;
      tick(2);
      chk_reset_outputs($sformatf("rst%0d", pass));
      req_q.delete();
      m_wbuf = 0; m_rbuf = 0; m_rvalid = 0;
      tick();
      ui_rst = 1'b0;
      seen = 0;
      if (pass == 0) begin
        repeat (15) begin tick(); if (fdma_wareq) seen++; end
        chk("rst0_no_wareq_without_start", seen, 0);
        pulse_start();
      end else begin
        pulse_start();
        n = 0;
        while (arb_phase == 4 && n < 40) begin
          if (fdma_wareq) seen++;
          tick(); n++;
        end
        chk("rst1_no_wareq_while_stale_busy", seen, 0);
      end
      $display("reset pass %0d: wareq_seen=%0d", pass, seen);
    end
    get_req(a);
    chk("rst_restart_addr", a, exp_addr(0, 0));
    get_bursts("rst_frame", 1, FB - 1);
    finish_frame("rst_frame");
    chk("no_wareq_while_busy", viol_cnt, 0);
    $display("after reset frame: rbuf=%0d wbuf=%0d", rbuf_idx, wbuf_idx);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
